add_serial: RTL
===============

# add_serial

Parametrised digit-serial adder/subtractor for the ALU datapath, extending the 1-bit full adder `add_full` to WIDTH-bit operands. It processes DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple stage and a registered carry. A start/busy/done handshake frames each operation. The block trades latency (WIDTH/DIGIT cycles) for area and sits between the operand registers and the ALU result mux.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of DIGIT.
- DIGIT, 4, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- c_in  input  1  carry in (add) or borrow in (subtract); sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; sum and c_out are valid from this cycle.
- sum  output  WIDTH  result; holds until the next completion.
- c_out  output  1  carry out of the MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  signed overflow (ADD_SERIAL_FLAGS_EN only).
- zero  output  1  sum == 0 (ADD_SERIAL_FLAGS_EN only).

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- States:
  - IDLE → RUN on start.
  - RUN: loops N cycles on a step counter of width ⌈log2 N⌉ (minimum 1).
  - RUN → DONE after step N-1.
  - DONE → IDLE, or directly back to RUN if start=1 in DONE.
- Start capture: A is captured as-is. B is captured inverted when sub=1. The carry register loads c_in when sub=0 and ~c_in when sub=1. Subtract therefore computes a − b − c_in = a + ~b + ~c_in.
- Each RUN cycle:
  - Adds the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shifts the DIGIT-bit result into the top of an internal result shift register.
  - Shifts A and B right by DIGIT.
  - Updates the carry register.
- On the last RUN step, the full result is transferred to the sum register and the final carry to c_out. sum and c_out change only at completion.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- Arithmetic is modulo 2^WIDTH. Carry out of the MSB appears only on c_out.
- Reset at any time, including mid-operation, aborts the operation. The state returns to IDLE and all internal registers clear.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0, ovf=0, zero=0.
- Edge 0 samples start=1 in IDLE. busy is high from after edge 0 through the cycle before done.
- done and valid sum/c_out/flags appear after edge N. Latency from start edge to done = N cycles.
- done is high exactly one cycle. busy=0 while done=1.
- Back-to-back: start asserted in the done cycle is accepted. The next done follows N cycles later, giving throughput of one operation per N cycles.
- busy and done are never high together.

## Configuration
- ADD_SERIAL_FLAGS_EN defined:
  - ovf and zero ports exist and update together with sum.
  - ovf = (effective A MSB == effective B MSB) && (sum MSB != A MSB), where effective B is the inverted B when sub=1.
  - zero = (sum == 0).
- ADD_SERIAL_FLAGS_EN undefined: the ovf and zero ports and their logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, DIGIT=4: a=0x1234, b=0x4321, sub=0, c_in=0 → sum=0x5555, c_out=0; done exactly 4 cycles after the start edge; busy high for the 4 preceding cycles.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1; with flags: zero=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, c_in=0 → sum=0xFFFE, c_out=0 (borrow). Then a=0x0007, b=0x0005, c_in=1 → sum=0x0001, c_out=1.
- Handshake: start held high for 10 cycles with new operands each cycle → only operations accepted while busy=0 complete. Outputs match the first operands captured (a=0x0010, b=0x0020 → sum=0x0030), then the operands sampled in the done cycle.
- Reset mid-operation: assert rst 2 cycles after start → busy, done, sum, c_out are 0 immediately and no done pulse follows. The next start (a=0x0001, b=0x0001) → sum=0x0002.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x00, c_in=1 → sum=0x00, c_out=1, done 8 cycles after start. Repeat with WIDTH=8, DIGIT=8 → done 1 cycle after start.

Source files
------------

// File: rtl/add_serial.sv
// -----------------------------------------------------------------------------
// add_serial
//
// Digit-serial adder/subtractor. Adds WIDTH-bit operands DIGIT bits per clock,
// LSB digit first, through a single DIGIT-bit ripple stage and a registered
// carry. A start/busy/done handshake frames each operation; the result takes
// WIDTH/DIGIT cycles from the accepting clock edge to the done pulse.
//
// Parameters
//   WIDTH  operand/result width (integer multiple of DIGIT)
//   DIGIT  bits added per cycle (1 .. WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start_i    request, sampled when not busy
//   sub_i      0 = add, 1 = subtract (sampled with start)
//   a_i, b_i   operands (sampled with start)
//   c_in_i     carry in (add) / borrow in (subtract)
//   busy_o     operation in progress
//   done_o     one-cycle completion pulse
//   sum_o      result, held until the next completion
//   c_out_o    carry out of the MSB (subtract: 1 = no borrow)
//   ovf_o      signed overflow      (only with ADD_SERIAL_FLAGS_EN)
//   zero_o     sum == 0             (only with ADD_SERIAL_FLAGS_EN)
//
// Build option: define ADD_SERIAL_FLAGS_EN to add the ovf_o/zero_o flags.
// -----------------------------------------------------------------------------
module add_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o
`ifdef ADD_SERIAL_FLAGS_EN
    ,
    output logic             ovf_o,
    output logic             zero_o
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
`ifdef ADD_SERIAL_FLAGS_EN
    // Operand sign bits are kept aside because the shift registers lose them.
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
`endif

    logic [DIGIT:0]     digit_sum;
    logic [WIDTH-1:0]   res_shift;
    logic [WIDTH-1:0]   b_eff;
    logic               load;

    // One ripple stage: low digit of each operand plus the carry register.
    assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

    // New digit enters at the top; after N steps the LSB digit is at bit 0.
    assign res_shift = (res_q >> DIGIT)
                     | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    // Subtraction is a + ~b + ~borrow.
    assign b_eff = sub_i ? ~b_i : b_i;

    // A new request is accepted in IDLE and in the DONE cycle (back-to-back).
    assign load = start_i && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef ADD_SERIAL_FLAGS_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_sum[DIGIT];
                res_d   = res_shift;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    sum_d   = res_shift;
                    c_out_d = digit_sum[DIGIT];
`ifdef ADD_SERIAL_FLAGS_EN
                    ovf_d   = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
                    zero_d  = (res_shift == '0);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d = S_RUN;
            cnt_d   = '0;
            a_d     = a_i;
            b_d     = b_eff;
            carry_d = c_in_i ^ sub_i;
            res_d   = '0;
`ifdef ADD_SERIAL_FLAGS_EN
            a_msb_d = a_i[WIDTH-1];
            b_msb_d = b_eff[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef ADD_SERIAL_FLAGS_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
`ifdef ADD_SERIAL_FLAGS_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy_o  = (state_q == S_RUN);
    assign done_o  = (state_q == S_DONE);
    assign sum_o   = sum_q;
    assign c_out_o = c_out_q;
`ifdef ADD_SERIAL_FLAGS_EN
    assign ovf_o   = ovf_q;
    assign zero_o  = zero_q;
`endif

endmodule
